line_burst_arbiter: RTL and testbench

- Sits between the L1 instruction and data caches and the burst memory port of `mp4`.
- Accepts 256-bit cacheline read/write requests from two clients, arbitrates between them round-robin, and turns each granted request into a 4-beat, 64-bit burst on `mem_*`.
- Returns the assembled line plus a one-cycle response to the winning client.

---
 rtl/line_burst_arbiter.sv | 151 +++++++++++++++
 tb/tb_line_burst_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_burst_arbiter.sv
// Round-robin arbiter between icache and dcache line requests, converting
// each granted 256-bit line transfer into a BEATS x 64-bit memory burst.
module line_burst_arbiter #(
  parameter int unsigned BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_line_read,
  input  logic [31:0]           i_line_addr,
  output logic [BEATS*64-1:0]   i_line_rdata,
  output logic                  i_line_resp,

  input  logic                  d_line_read,
  input  logic                  d_line_write,
  input  logic [31:0]           d_line_addr,
  input  logic [BEATS*64-1:0]   d_line_wdata,
  output logic [BEATS*64-1:0]   d_line_rdata,
  output logic                  d_line_resp,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_addr,
  output logic [63:0]           mem_wdata,
  input  logic [63:0]           mem_rdata,
  input  logic                  mem_resp
);

  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } gnt_t;

  state_t              state, state_nxt;
  gnt_t                last_grant, grant_nxt;
  logic [BW-1:0]       beat;
  logic [31:0]         addr_q;
  logic [BEATS-1:0][63:0] line_buf;

  logic                i_req;
  logic                d_req;
  logic                last_beat;
  logic [31:0]         sel_addr;

  assign i_req     = i_line_read;
  assign d_req     = d_line_read | d_line_write;
  assign last_beat = mem_resp && (beat == BW'(BEATS - 1));
  assign sel_addr  = (grant_nxt == GNT_D) ? d_line_addr : i_line_addr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and arbitration
  always_comb begin
    state_nxt = state;
    grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          grant_nxt = (last_grant == GNT_D) ? GNT_I : GNT_D;
        end else if (i_req) begin
          grant_nxt = GNT_I;
        end else if (d_req) begin
          grant_nxt = GNT_D;
        end
        // a simultaneous dcache read+write resolves to a writeback
        if (i_req || d_req) begin
          state_nxt = (grant_nxt == GNT_D && d_line_write) ? WR : RD;
        end
      end
      RD, WR: begin
        if (last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: grant bookkeeping, address latch, beat counter, line buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_D;
      beat       <= '0;
      addr_q     <= '0;
      line_buf   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (state_nxt != IDLE) begin
            last_grant <= grant_nxt;
            beat       <= '0;
            addr_q     <= sel_addr & 32'hFFFF_FFE0;
            if (state_nxt == WR) begin
              line_buf <= d_line_wdata;
            end
          end
        end
        RD: begin
          if (mem_resp) begin
            line_buf[beat] <= mem_rdata;
            beat           <= beat + 1'b1;
          end
        end
        WR: begin
          if (mem_resp) begin
            beat <= beat + 1'b1;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode directly from registered state, so they are glitch-free
  // and rise the cycle after the grant.
  always_comb begin
    mem_read     = (state == RD);
    mem_write    = (state == WR);
    mem_addr     = addr_q;
    mem_wdata    = line_buf[beat];
    i_line_resp  = (state == DONE) && (last_grant == GNT_I);
    d_line_resp  = (state == DONE) && (last_grant == GNT_D);
    i_line_rdata = line_buf;
    d_line_rdata = line_buf;
  end

endmodule

// File: tb/tb_line_burst_arbiter.sv
// Directed self-checking bench for line_burst_arbiter with a behavioural
// burst memory that inserts a configurable number of wait cycles per beat.
module tb_line_burst_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_line_read;
  logic [31:0]   i_line_addr;
  logic [255:0]  i_line_rdata;
  logic          i_line_resp;
  logic          d_line_read;
  logic          d_line_write;
  logic [31:0]   d_line_addr;
  logic [255:0]  d_line_wdata;
  logic [255:0]  d_line_rdata;
  logic          d_line_resp;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;
  logic          mem_resp;

  line_burst_arbiter #(.BEATS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_line_read  (i_line_read),
    .i_line_addr  (i_line_addr),
    .i_line_rdata (i_line_rdata),
    .i_line_resp  (i_line_resp),
    .d_line_read  (d_line_read),
    .d_line_write (d_line_write),
    .d_line_addr  (d_line_addr),
    .d_line_wdata (d_line_wdata),
    .d_line_rdata (d_line_rdata),
    .d_line_resp  (d_line_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] rbeats [4];
  int          wait_cfg = 0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  logic [63:0] wcyc [$];
  logic [31:0] burst_addr;
  logic        addr_moved;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic clear_log();
    rd_cycles = 0;
    wr_cycles = 0;
    wcyc.delete();
  endtask

  // Memory model: decides mem_resp shortly after each edge from the DUT's
  // registered request outputs.
  initial begin
    int idx = 0;
    int wcnt = 0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_read || mem_write) begin
        if (mem_read) rd_cycles++;
        if (mem_write) begin
          wr_cycles++;
          wcyc.push_back(mem_wdata);
        end
        if (wcnt >= wait_cfg) begin
          mem_resp  = 1'b1;
          mem_rdata = rbeats[idx];
          idx       = (idx + 1) % 4;
          wcnt      = 0;
        end else begin
          mem_resp  = 1'b0;
          mem_rdata = '0;
          wcnt++;
        end
      end else begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        idx       = 0;
        wcnt      = 0;
      end
    end
  end

  task automatic wait_resp(input string tag, output int cyc);
    logic got;
    logic seen;
    got        = 1'b0;
    seen       = 1'b0;
    addr_moved = 1'b0;
    cyc        = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      cyc++;
      if (mem_read || mem_write) begin
        if (!seen) begin
          burst_addr = mem_addr;
          seen       = 1'b1;
        end else if (mem_addr !== burst_addr) begin
          addr_moved = 1'b1;
        end
      end
      if (i_line_resp || d_line_resp) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_resp_seen"}, got, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    int nresp;
    logic exp_i;

    rst          = 1'b1;
    i_line_read  = 1'b0;
    i_line_addr  = '0;
    d_line_read  = 1'b0;
    d_line_write = 1'b0;
    d_line_addr  = '0;
    d_line_wdata = '0;
    rbeats[0] = 64'h1111_1111_1111_1111;
    rbeats[1] = 64'h2222_2222_2222_2222;
    rbeats[2] = 64'h3333_3333_3333_3333;
    rbeats[3] = 64'h4444_4444_4444_4444;
    do_reset();

    check("rst_mem_read",  mem_read,     1'b0);
    check("rst_mem_write", mem_write,    1'b0);
    check("rst_mem_addr",  mem_addr,     32'h0);
    check("rst_mem_wdata", mem_wdata,    64'h0);
    check("rst_i_resp",    i_line_resp,  1'b0);
    check("rst_d_resp",    d_line_resp,  1'b0);
    check("rst_rdata",     i_line_rdata, 256'h0);

    // 1: icache alone, zero-wait memory
    clear_log();
    wait_cfg    = 0;
    i_line_read = 1'b1;
    i_line_addr = 32'h0000_1234;
    wait_resp("t1", cyc);
    i_line_read = 1'b0;
    check("t1_latency",  cyc,          5);
    check("t1_addr",     burst_addr,   32'h0000_1220);
    check("t1_addr_hold", addr_moved,  1'b0);
    check("t1_i_resp",   i_line_resp,  1'b1);
    check("t1_d_resp",   d_line_resp,  1'b0);
    check("t1_rdata",    i_line_rdata,
          {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    check("t1_rd_cycles", rd_cycles,   4);
    check("t1_mem_read_done", mem_read, 1'b0);
    tick();
    check("t1_resp_one_cycle", i_line_resp, 1'b0);

    // 2: dcache writeback with two wait cycles per beat
    clear_log();
    wait_cfg     = 2;
    d_line_write = 1'b1;
    d_line_addr  = 32'h8000_00E0;
    d_line_wdata = {64'hD, 64'hC, 64'hB, 64'hA};
    wait_resp("t2", cyc);
    d_line_write = 1'b0;
    check("t2_latency",   cyc,         13);
    check("t2_addr",      burst_addr,  32'h8000_00E0);
    check("t2_addr_hold", addr_moved,  1'b0);
    check("t2_d_resp",    d_line_resp, 1'b1);
    check("t2_i_resp",    i_line_resp, 1'b0);
    check("t2_mem_write_done", mem_write, 1'b0);
    check("t2_rd_cycles", rd_cycles,   0);
    check("t2_wr_cycles", wr_cycles,   12);
    check("t2_wcyc_len",  wcyc.size(), 12);
    for (int k = 0; k < 12 && k < wcyc.size(); k++) begin
      check($sformatf("t2_wdata_%0d", k), wcyc[k], 64'hA + 64'(k / 3));
    end
    wait_cfg = 0;
    tick();

    // 3: simultaneous requests held across three transactions
    do_reset();
    clear_log();
    i_line_read = 1'b1;
    i_line_addr = 32'h0000_0100;
    d_line_read = 1'b1;
    d_line_addr = 32'h0000_0200;
    for (int n = 0; n < 3; n++) begin
      wait_resp($sformatf("t3_%0d", n), cyc);
      exp_i = (n != 1);
      if (n == 2) begin
        i_line_read = 1'b0;
        d_line_read = 1'b0;
      end
      check($sformatf("t3_i_resp_%0d", n), i_line_resp, exp_i);
      check($sformatf("t3_d_resp_%0d", n), d_line_resp, !exp_i);
      check($sformatf("t3_addr_%0d", n), burst_addr,
            exp_i ? 32'h0000_0100 : 32'h0000_0200);
    end
    check("t3_wr_cycles", wr_cycles, 0);
    tick();

    // 4: dcache read and write both high resolves to a write
    clear_log();
    d_line_read  = 1'b1;
    d_line_write = 1'b1;
    d_line_addr  = 32'h0000_3300;
    d_line_wdata = {64'h4, 64'h3, 64'h2, 64'h1};
    wait_resp("t4", cyc);
    d_line_read  = 1'b0;
    d_line_write = 1'b0;
    check("t4_d_resp",    d_line_resp, 1'b1);
    check("t4_rd_cycles", rd_cycles,   0);
    check("t4_wr_cycles", wr_cycles,   4);
    tick();

    // 5: reset after the second beat of a read
    clear_log();
    i_line_read = 1'b1;
    i_line_addr = 32'h0000_5000;
    nresp = 0;
    for (int k = 0; k < 50 && nresp < 2; k++) begin
      tick();
      if (mem_resp) nresp++;
    end
    check("t5_two_beats", nresp, 2);
    rst         = 1'b1;
    i_line_read = 1'b0;
    tick();
    rst = 1'b0;
    check("t5_mem_read",  mem_read,     1'b0);
    check("t5_i_resp",    i_line_resp,  1'b0);
    check("t5_rdata_clr", i_line_rdata, 256'h0);
    tick();
    check("t5_no_resp_later", i_line_resp | d_line_resp, 1'b0);
    rbeats[0] = 64'h5555_5555_5555_5555;
    rbeats[1] = 64'h6666_6666_6666_6666;
    rbeats[2] = 64'h7777_7777_7777_7777;
    rbeats[3] = 64'h8888_8888_8888_8888;
    i_line_read = 1'b1;
    i_line_addr = 32'h0000_601F;
    wait_resp("t5b", cyc);
    i_line_read = 1'b0;
    check("t5b_addr",  burst_addr, 32'h0000_6000);
    check("t5b_rdata", i_line_rdata,
          {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
           64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
    tick();

    // 6: request held across DONE restarts after one dead IDLE cycle
    i_line_read = 1'b1;
    i_line_addr = 32'h0000_444C;
    wait_resp("t6", cyc);
    check("t6_i_resp", i_line_resp, 1'b1);
    tick();
    check("t6_gap_read", mem_read, 1'b0);
    tick();
    check("t6_restart_read", mem_read, 1'b1);
    check("t6_restart_addr", mem_addr, 32'h0000_4440);
    wait_resp("t6b", cyc);
    i_line_read = 1'b0;
    check("t6b_i_resp", i_line_resp, 1'b1);
    check("t6b_rdata", i_line_rdata,
          {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
           64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
